rtc_alrm_sched: RTL and testbench

- Multiplexes SLOT_NUM software alarm slots onto the single RTC alarm comparator.
- Scans the armed slots and picks the one nearest in the future relative to the live counter (wrap-aware). Drives that slot's value as the alarm target.
- On a counter match, fires every armed slot holding that value, then rescans.
- Sits beside the APB RTC in the bus-clock domain; consumes the already-synchronised counter value.

---
 rtl/rtc_alrm_sched.sv | 142 ++++++++++++++
 tb/tb_rtc_alrm_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_alrm_sched.sv
// Multiplexes SLOT_NUM software alarm slots onto one RTC alarm comparator (nearest-future, wrap-aware).
// Optional macro RTC_ALRM_SCHED_PERIODIC_EN adds per-slot periods that re-arm a slot after it fires.
module rtc_alrm_sched #(
    parameter  int SLOT_NUM  = 4,
    parameter  int CNT_WIDTH = 32,
    localparam int IDX_WIDTH = $clog2(SLOT_NUM)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 cnt_jmp_i,
    input  logic                 wr_en_i,
    input  logic [IDX_WIDTH-1:0] wr_idx_i,
    input  logic [CNT_WIDTH-1:0] wr_val_i,
    input  logic                 wr_arm_i,
`ifdef RTC_ALRM_SCHED_PERIODIC_EN
    input  logic [CNT_WIDTH-1:0] per_i,
`endif
    output logic [CNT_WIDTH-1:0] alrm_o,
    output logic                 alrm_vld_o,
    output logic [SLOT_NUM-1:0]  fire_o,
    output logic [SLOT_NUM-1:0]  armed_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {IDLE, SCAN, LOAD, WAIT, FIRE} state_t;

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] val [SLOT_NUM];
`ifdef RTC_ALRM_SCHED_PERIODIC_EN
    logic [CNT_WIDTH-1:0] per [SLOT_NUM];
`endif
    logic [SLOT_NUM-1:0]  armed;
    logic [IDX_WIDTH-1:0] scan_idx;
    logic [IDX_WIDTH-1:0] best_idx;
    logic [CNT_WIDTH-1:0] best_dist;
    logic                 best_found;

    logic [SLOT_NUM-1:0]  wr_sel;
    logic                 wr_ok;
    logic                 wr_arms;
    logic                 rescan;
    logic [CNT_WIDTH-1:0] cur_dist;
    logic                 last;
    logic                 take;

    // An out-of-range index shifts the one-hot select to zero, so the write vanishes.
    assign wr_sel   = wr_en_i ? (SLOT_NUM'(1) << wr_idx_i) : '0;
    assign wr_ok    = |wr_sel;
    assign wr_arms  = wr_ok && wr_arm_i;
    assign rescan   = wr_ok || cnt_jmp_i;

    assign cur_dist = val[scan_idx] - cnt_i;
    assign last     = (scan_idx == IDX_WIDTH'(SLOT_NUM - 1));
    assign take     = armed[scan_idx] && (!best_found || (cur_dist < best_dist));
    assign armed_o  = armed;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (wr_arms) state_n = SCAN;
            SCAN: begin
                if (rescan)    state_n = SCAN;
                else if (last) state_n = (best_found || take) ? LOAD : IDLE;
            end
            LOAD: state_n = rescan ? SCAN : WAIT;
            // A match outranks any concurrent write or jump.
            WAIT: begin
                if (cnt_i == alrm_o) state_n = FIRE;
                else if (rescan)     state_n = SCAN;
            end
            FIRE: state_n = SCAN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            alrm_o     <= '0;
            alrm_vld_o <= 1'b0;
            busy_o     <= 1'b0;
            scan_idx   <= '0;
            best_idx   <= '0;
            best_dist  <= '0;
            best_found <= 1'b0;
        end else begin
            state      <= state_n;
            alrm_vld_o <= (state_n == WAIT);
            busy_o     <= (state_n == SCAN) || (state_n == LOAD);
            if ((state_n == SCAN) && ((state != SCAN) || rescan)) begin
                scan_idx   <= '0;
                best_idx   <= '0;
                best_dist  <= '0;
                best_found <= 1'b0;
            end else if (state == SCAN) begin
                scan_idx <= scan_idx + 1'b1;
                if (take) begin
                    best_found <= 1'b1;
                    best_idx   <= scan_idx;
                    best_dist  <= cur_dist;
                end
            end
            if ((state == LOAD) && (state_n == WAIT)) alrm_o <= val[best_idx];
        end
    end

    // Slot storage: the fire clear comes first so a same-cycle write overrides it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            armed  <= '0;
            fire_o <= '0;
            for (int i = 0; i < SLOT_NUM; i++) begin
                val[i] <= '0;
`ifdef RTC_ALRM_SCHED_PERIODIC_EN
                per[i] <= '0;
`endif
            end
        end else begin
            fire_o <= '0;
            for (int i = 0; i < SLOT_NUM; i++) begin
                if ((state == FIRE) && armed[i] && (val[i] == alrm_o)) begin
                    fire_o[i] <= 1'b1;
`ifdef RTC_ALRM_SCHED_PERIODIC_EN
                    if (per[i] != '0) val[i] <= val[i] + per[i];
                    else              armed[i] <= 1'b0;
`else
                    armed[i] <= 1'b0;
`endif
                end
                if (wr_sel[i]) begin
                    armed[i] <= wr_arm_i;
                    if (wr_arm_i) val[i] <= wr_val_i;
`ifdef RTC_ALRM_SCHED_PERIODIC_EN
                    per[i] <= per_i;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_rtc_alrm_sched.sv
// Scoreboard bench for rtc_alrm_sched: expected fire vectors queued at stimulus time, popped as fire_o pulses.
module tb_rtc_alrm_sched;
    localparam int SLOT_NUM  = 4;
    localparam int CNT_WIDTH = 32;
    localparam int IDX_WIDTH = $clog2(SLOT_NUM);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [CNT_WIDTH-1:0] cnt = '0;
    logic                 cnt_jmp = 1'b0;
    logic                 wr_en = 1'b0;
    logic [IDX_WIDTH-1:0] wr_idx = '0;
    logic [CNT_WIDTH-1:0] wr_val = '0;
    logic                 wr_arm = 1'b0;
    logic [CNT_WIDTH-1:0] alrm;
    logic                 alrm_vld;
    logic [SLOT_NUM-1:0]  fire;
    logic [SLOT_NUM-1:0]  armed;
    logic                 busy;

    int errors = 0;
    int checks = 0;
    logic [SLOT_NUM-1:0] exp_fire [$];

    always #5 clk = ~clk;

    rtc_alrm_sched #(.SLOT_NUM(SLOT_NUM), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .cnt_i     (cnt),
        .cnt_jmp_i (cnt_jmp),
        .wr_en_i   (wr_en),
        .wr_idx_i  (wr_idx),
        .wr_val_i  (wr_val),
        .wr_arm_i  (wr_arm),
`ifdef RTC_ALRM_SCHED_PERIODIC_EN
        .per_i     ('0),
`endif
        .alrm_o    (alrm),
        .alrm_vld_o(alrm_vld),
        .fire_o    (fire),
        .armed_o   (armed),
        .busy_o    (busy)
    );

    always @(negedge clk) begin
        if (!rst && (fire != '0)) begin
            checks++;
            if (exp_fire.size() == 0) begin
                errors++;
                $display("FAIL unexpected_fire: fire_o=%b, none expected", fire);
            end else begin
                logic [SLOT_NUM-1:0] e;
                e = exp_fire.pop_front();
                if (fire !== e) begin
                    errors++;
                    $display("FAIL fire_vector: fire_o=%b expected=%b", fire, e);
                end
            end
        end
    end

    task automatic write_slot(input int idx, input logic [CNT_WIDTH-1:0] v, input logic arm);
        wr_en  = 1'b1;
        wr_idx = IDX_WIDTH'(idx);
        wr_val = v;
        wr_arm = arm;
        @(negedge clk);
        wr_en  = 1'b0;
    endtask

    task automatic wait_vld(input logic [CNT_WIDTH-1:0] exp, input int exp_lat, input string name);
        int n = 0;
        while (!alrm_vld && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!alrm_vld) begin
            errors++;
            $display("FAIL %s: alrm_vld_o timeout after %0d cycles", name, n);
        end else if (alrm !== exp) begin
            errors++;
            $display("FAIL %s: alrm_o=%h expected=%h", name, alrm, exp);
        end
        if (exp_lat > 0) begin
            checks++;
            if (n !== exp_lat) begin
                errors++;
                $display("FAIL %s_latency: got %0d cycles expected %0d", name, n, exp_lat);
            end
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_fire.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_fire.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected fires never seen", name, exp_fire.size());
            exp_fire.delete();
        end
    endtask

    task automatic check_idle(input logic [SLOT_NUM-1:0] exp_armed, input string name);
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || alrm_vld !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b vld=%b expected 0/0", name, busy, alrm_vld);
        end
        checks++;
        if (armed !== exp_armed) begin
            errors++;
            $display("FAIL %s_armed: armed_o=%b expected=%b", name, armed, exp_armed);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (alrm !== '0 || alrm_vld !== 1'b0 || fire !== '0 || armed !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: alrm=%h vld=%b fire=%b armed=%b busy=%b expected all 0",
                     alrm, alrm_vld, fire, armed, busy);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        cnt = 32'd10;
        write_slot(2, 32'd100, 1'b1);
        write_slot(0, 32'd50, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: busy_o=%b expected 1", busy);
        end
        wait_vld(32'd50, SLOT_NUM + 1, "basic_first");
        exp_fire.push_back(4'b0001);
        cnt = 32'd50;
        drain("basic_fire50");
        wait_vld(32'd100, 0, "basic_second");
        exp_fire.push_back(4'b0100);
        cnt = 32'd100;
        drain("basic_fire100");
        check_idle(4'b0000, "basic");
    endtask

    task automatic test_wrap();
        cnt = 32'hFFFF_FFF0;
        write_slot(1, 32'h0000_0010, 1'b1);
        write_slot(3, 32'hFFFF_FFF8, 1'b1);
        wait_vld(32'hFFFF_FFF8, 0, "wrap_first");
        exp_fire.push_back(4'b1000);
        cnt = 32'hFFFF_FFF8;
        drain("wrap_fire_hi");
        wait_vld(32'h0000_0010, 0, "wrap_second");
        exp_fire.push_back(4'b0010);
        cnt = 32'h0000_0010;
        drain("wrap_fire_lo");
        check_idle(4'b0000, "wrap");
    endtask

    task automatic test_equal();
        cnt = 32'd150;
        write_slot(0, 32'd200, 1'b1);
        write_slot(1, 32'd200, 1'b1);
        wait_vld(32'd200, 0, "equal_target");
        exp_fire.push_back(4'b0011);
        cnt = 32'd200;
        drain("equal_fire");
        check_idle(4'b0000, "equal");
    endtask

    task automatic test_rescan();
        cnt = 32'd300;
        write_slot(0, 32'd500, 1'b1);
        wait_vld(32'd500, 0, "rescan_initial");
        write_slot(3, 32'd400, 1'b1);
        wait_vld(32'd400, SLOT_NUM + 1, "rescan_new");
        write_slot(3, 32'd400, 1'b0);
        wait_vld(32'd500, SLOT_NUM + 1, "rescan_disarm");
        checks++;
        if (armed !== 4'b0001) begin
            errors++;
            $display("FAIL rescan_armed: armed_o=%b expected=0001", armed);
        end
        exp_fire.push_back(4'b0001);
        cnt = 32'd500;
        drain("rescan_fire");
        check_idle(4'b0000, "rescan");
    endtask

    task automatic test_jump();
        cnt = 32'd300;
        write_slot(0, 32'd500, 1'b1);
        write_slot(1, 32'd700, 1'b1);
        wait_vld(32'd500, 0, "jump_before");
        cnt     = 32'd600;
        cnt_jmp = 1'b1;
        @(negedge clk);
        cnt_jmp = 1'b0;
        wait_vld(32'd700, SLOT_NUM + 1, "jump_after");
        exp_fire.push_back(4'b0010);
        cnt = 32'd700;
        drain("jump_fire");
        wait_vld(32'd500, 0, "jump_remaining");
        write_slot(0, 32'd0, 1'b0);
        check_idle(4'b0000, "jump");
    endtask

    task automatic test_back_to_back();
        // Match and arming write in the same WAIT cycle: the new slot joins the fire set.
        cnt = 32'd700;
        write_slot(2, 32'd800, 1'b1);
        wait_vld(32'd800, 0, "b2b_target");
        exp_fire.push_back(4'b0110);
        cnt = 32'd800;
        write_slot(1, 32'd800, 1'b1);
        drain("b2b_match_write");
        check_idle(4'b0000, "b2b_match_write");
        // Re-arming the firing slot during FIRE wins, so it fires again at once.
        cnt = 32'd900;
        write_slot(0, 32'd1000, 1'b1);
        wait_vld(32'd1000, 0, "b2b_rearm_target");
        exp_fire.push_back(4'b0001);
        exp_fire.push_back(4'b0001);
        cnt = 32'd1000;
        @(negedge clk);
        write_slot(0, 32'd1000, 1'b1);
        drain("b2b_rearm_fire");
        check_idle(4'b0000, "b2b_rearm");
    endtask

    task automatic test_reset_midscan();
        cnt = 32'd5;
        write_slot(1, 32'd20, 1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midscan_busy: busy_o=%b expected 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || armed !== '0 || alrm_vld !== 1'b0 || alrm !== '0) begin
            errors++;
            $display("FAIL midscan_reset: busy=%b armed=%b vld=%b alrm=%h expected 0",
                     busy, armed, alrm_vld, alrm);
        end
        @(negedge clk);
        rst = 1'b0;
        check_idle(4'b0000, "midscan_after");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_equal();
        test_rescan();
        test_jump();
        test_back_to_back();
        test_reset_midscan();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_fire.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_fire.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
